// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, response FSM states and lane count for the data-memory lane controller
package dmem_pkg;
    localparam int LANES = 4;
    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, HOLD = 2'd2} state_e;
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: extracts a byte/half/word from the four lane read bytes and zero/sign-extends it
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] lane_rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] rdata
);
    logic [1:0]  eff;
    logic [31:0] sh;
    // Words always start at lane 0 and halves at lane 0 or 2, so low offset bits drop out here
    assign eff   = size[1] ? 2'd0 : (size == SZ_HALF) ? {off[1], 1'b0} : off;
    assign sh    = lane_rdata >> {eff, 3'b000};
    assign rdata = size[1] ? sh :
                   (size == SZ_HALF) ? {{16{sgn & sh[15]}}, sh[15:0]} :
                   {{24{sgn & sh[7]}}, sh[7:0]};
endmodule

// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl: byte-lane write steering and aligned load responses with a stall hold register.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_lane_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR+1:0]   req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR-1:0]   lane_addr,
    output logic [LANES-1:0]  lane_we,
    output logic [31:0]       lane_wdata,
    input  logic [31:0]       lane_rdata
);
    state_e      state, state_nx;
    logic [1:0]  off, c_off, c_size;
    logic        c_sgn, c_nul, fire, trap;
    logic [3:0]  mask;
    logic [31:0] fmt, live, hold_q;

    assign off        = req_addr[1:0];
    assign req_ready  = rst_n && (!rsp_valid || rsp_ready);
    assign fire       = req_valid && req_ready;
    assign mask       = req_size[1] ? 4'b1111 :
                        (req_size == SZ_HALF) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    assign lane_we    = (fire && req_we && !trap) ? mask : '0;
    assign lane_wdata = req_size[1] ? req_wdata :
                        (req_size == SZ_HALF) ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
    assign lane_addr  = req_addr[ADDR+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic c_err;
    assign trap    = req_size[1] ? (off != 2'd0) : (req_size == SZ_HALF) && off[0];
    assign rsp_err = rsp_valid && c_err;
    // Remember whether the outstanding response belongs to a trapped access
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) c_err <= 1'b0;
        else if (fire) c_err <= trap;
`else
    assign trap    = 1'b0;
    assign rsp_err = 1'b0;
`endif

    dmem_load_align u_align (
        .lane_rdata (lane_rdata),
        .off        (c_off),
        .size       (c_size),
        .sgn        (c_sgn),
        .rdata      (fmt)
    );

    // Stores and trapped accesses carry no data
    assign live = c_nul ? '0 : fmt;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // A new accept always opens a live response; an unconsumed response falls into HOLD
    always_comb state_nx = fire ? RESP : (state != IDLE && !rsp_ready) ? HOLD : IDLE;

    // Response outputs: live format in RESP, snapshot in HOLD, zero when idle
    always_comb begin
        rsp_valid = state != IDLE;
        rsp_rdata = (state == RESP) ? live : (state == HOLD) ? hold_q : '0;
    end

    // Capture request attributes on accept; snapshot the data before the lane RAMs reload
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            c_off  <= '0;
            c_size <= '0;
            c_sgn  <= 1'b0;
            c_nul  <= 1'b0;
            hold_q <= '0;
        end else begin
            if (fire) begin
                c_off  <= off;
                c_size <= req_size;
                c_sgn  <= req_signed;
                c_nul  <= req_we || trap;
            end
            if (state == RESP && !rsp_ready) hold_q <= live;
        end
endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// tb_dmem_lane_ctrl: lane RAM environment plus byte-memory reference model with directed and random traffic
module tb_dmem_lane_ctrl;
    localparam int ADDR = 12;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic [ADDR+1:0]   req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              req_ready, rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata, lane_wdata, lane_rdata;
    logic [ADDR-1:0]   lane_addr;
    logic [3:0]        lane_we;
    logic              ram_clr = 1'b1;
    logic [7:0]        ram [4][1<<ADDR];
    logic [7:0]        ref_mem [1<<(ADDR+2)];
    int                n_chk = 0, n_fail = 0;
    logic              slot_v, slot_e;
    logic [31:0]       slot_d;
    logic [31:0]       o_rd, o_wd;
    logic [3:0]        o_we;
    logic              o_rr, o_rv, o_err;

    always #5 clk = ~clk;

    dmem_lane_ctrl #(.ADDR(ADDR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .lane_addr  (lane_addr),
        .lane_we    (lane_we),
        .lane_wdata (lane_wdata),
        .lane_rdata (lane_rdata)
    );

    // Four write-first byte-lane RAMs with registered read address
    always @(posedge clk)
        for (int l = 0; l < 4; l++) begin
            if (ram_clr) for (int a = 0; a < (1 << ADDR); a++) ram[l][a] <= 8'h00;
            else if (lane_we[l]) ram[l][lane_addr] <= lane_wdata[8*l+:8];
            lane_rdata[8*l+:8] <= lane_we[l] ? lane_wdata[8*l+:8] : ram[l][lane_addr];
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    task automatic cyc(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                       input int addr, input logic [31:0] wd, input logic rr);
        int n, a;
        logic fire, trap;
        logic [3:0] em;
        logic [31:0] ew, bm, x;
        @(negedge clk);
        req_valid = v; req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr[ADDR+1:0]; req_wdata = wd; rsp_ready = rr;
        #1;
        o_rd = rsp_rdata; o_wd = lane_wdata; o_we = lane_we; o_rr = req_ready; o_rv = rsp_valid; o_err = rsp_err;
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, slot_v});
        check("rsp_rdata", rsp_rdata, slot_v ? slot_d : 32'd0);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, slot_v && slot_e});
        check("req_ready", {31'd0, req_ready}, {31'd0, !slot_v || rr});
        fire = v && (!slot_v || rr);
        n = nbytes(sz);
        a = addr - addr % n;
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = (addr % n) != 0;
`else
        trap = 1'b0;
`endif
        em = '0; ew = '0; bm = '0;
        if (fire && we && !trap)
            for (int i = 0; i < n; i++) begin
                em[(a + i) % 4] = 1'b1;
                ew[8*((a + i) % 4)+:8] = wd[8*i+:8];
                bm[8*((a + i) % 4)+:8] = 8'hFF;
            end
        check("lane_we", {28'd0, lane_we}, {28'd0, em});
        if (em != 4'd0) check("lane_wdata", lane_wdata & bm, ew);
        if (fire) check("lane_addr", {20'd0, lane_addr}, addr / 4);
        if (slot_v && rr) slot_v = 1'b0;
        if (fire) begin
            slot_v = 1'b1; slot_e = trap; slot_d = '0;
            if (!we && !trap) begin
                x = '0;
                for (int i = 0; i < n; i++) x[8*i+:8] = ref_mem[a + i];
                if (sg && n < 4 && x[8*n-1]) x = x | (32'hFFFFFFFF << (8 * n));
                slot_d = x;
            end
            if (we && !trap) for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i+:8];
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 0, 32'd0, 1'b1);
    endtask

    initial begin
        slot_v = 1'b0; slot_e = 1'b0; slot_d = '0;
        for (int i = 0; i < (1 << (ADDR + 2)); i++) ref_mem[i] = 8'h00;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_lane_we", {28'd0, lane_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ram_clr = 1'b0; req_valid = 1'b0;

        cyc(1, 1, 2, 0, 'h010, 32'hDEADBEEF, 1);
        check("st_w_we", {28'd0, o_we}, 32'h0000000F);
        cyc(1, 0, 2, 0, 'h010, 0, 1);
        idle();
        check("ld_w_data", o_rd, 32'hDEADBEEF);

        cyc(1, 1, 0, 0, 'h013, 32'h0000005A, 1);
        check("st_b_we", {28'd0, o_we}, 32'h00000008);
        check("st_b_wd", o_wd, 32'h5A5A5A5A);
        cyc(1, 1, 0, 0, 'h013, 32'h00000080, 1);
        cyc(1, 0, 0, 1, 'h013, 0, 1);
        cyc(1, 0, 0, 0, 'h013, 0, 1);
        check("ld_bs_data", o_rd, 32'hFFFFFF80);
        idle();
        check("ld_bu_data", o_rd, 32'h00000080);

        cyc(1, 1, 2, 0, 'h010, 32'h80011234, 1);
        cyc(1, 0, 1, 1, 'h012, 0, 1);
        cyc(1, 0, 1, 0, 'h010, 0, 1);
        check("ld_hs_data", o_rd, 32'hFFFF8001);
        idle();
        check("ld_hu_data", o_rd, 32'h00001234);

        cyc(1, 1, 2, 0, 'h020, 32'hCAFEF00D, 1);
        cyc(1, 0, 2, 0, 'h020, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 2, 0, 4 * (i + 1), 0, 0);
            check("hold_rd", o_rd, 32'hCAFEF00D);
            check("hold_rr", {31'd0, o_rr}, 32'd0);
        end
        cyc(1, 0, 2, 0, 'h010, 0, 1);
        check("retire_rd", o_rd, 32'hCAFEF00D);
        check("retire_rr", {31'd0, o_rr}, 32'd1);
        idle();
        check("next_rd", o_rd, 32'h80011234);

        for (int i = 0; i < 3; i++) cyc(1, 1, 2, 0, 4 * i, 32'h11111111 * (i + 1), 1);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) cyc(1, 0, 2, 0, 4 * i, 0, 1);
            else idle();
            if (i > 0) begin
                check("b2b_valid", {31'd0, o_rv}, 32'd1);
                check("b2b_data", o_rd, 32'h11111111 * i);
            end
        end

        cyc(1, 1, 2, 0, 'h011, 32'hA5A5A5A5, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_we", {28'd0, o_we}, 32'd0);
        idle();
        check("mis_err", {31'd0, o_err}, 32'd1);
        check("mis_rd", o_rd, 32'd0);
`else
        check("mis_we", {28'd0, o_we}, 32'h0000000F);
        cyc(1, 0, 2, 0, 'h010, 0, 1);
        idle();
        check("mis_rd", o_rd, 32'hA5A5A5A5);
`endif

        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 1'($urandom),
                $urandom_range(0, 63), $urandom, $urandom_range(0, 3) != 0);
        repeat (3) idle();

        cyc(1, 0, 2, 0, 'h000, 0, 1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; rsp_ready = 1'b0;
        #1;
        check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, rsp_valid}, 32'd0);
        check("arst_rdata", rsp_rdata, 32'd0);
        check("arst_ready", {31'd0, req_ready}, 32'd0);
        check("arst_we", {28'd0, lane_we}, 32'd0);
        slot_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b0;
        repeat (3) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_lane_ctrl.md
Name: dmem_lane_ctrl

Overview:
- Bus-side controller that sits directly upstream of the four 8-bit data-memory byte-lane RAMs (b0..b3); it drives their write port and consumes their registered-address read data.
- Converts 32-bit byte-addressed load/store requests (byte/half/word) into per-lane write enables and lane-replicated write data.
- Aligns and sign/zero-extends read data.
- Provides a valid/ready response path with a hold register, so back-pressure never loses a read, even though the lane RAMs ignore their clock enable.

Parameters:
- ADDR, 12, lane RAM address width; byte address width is ADDR+2.

Ports:
- clk  in  1  system clock; lane RAMs share it
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
- req_signed  in  1  sign-extend loads
- req_addr  in  ADDR+2  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  load result, extended; 0 for stores and when rsp_valid=0
- rsp_err  out  1  misaligned access (only with the optional feature)
- lane_addr  out  ADDR  req_addr[ADDR+1:2]; common to all lanes
- lane_we  out  4  per-lane write enable, bit n to lane bn
- lane_wdata  out  32  lane n gets bits [8n+7:8n]
- lane_rdata  in  32  {b3,b2,b1,b0} read data; valid the cycle after the address edge

Behaviour:
- Reset values: rsp_valid=0, rsp_err=0, rsp_rdata=0, state IDLE, hold register 0. req_ready=0 and lane_we=0 while rst_n is low.
- req_ready = !rsp_valid || rsp_ready (combinational). A new request is accepted in the same cycle the previous response retires.
- Accept is fire = req_valid && req_ready. lane_we is nonzero only on fire && req_we.
- Byte offset is off = req_addr[1:0]. On fire, off, size, signed and we are captured into response registers.
- Store lanes:
  - byte: lane_we = 1<<off; wdata[7:0] replicated to all lanes.
  - half: lane_we = off[1] ? 4'b1100 : 4'b0011; wdata[15:0] replicated.
  - word: lane_we = 4'b1111; lane_wdata = wdata.
- Load extract: from lane_rdata shifted right by 8*captured off, then zero- or sign-extended from bit 7 (byte) or bit 15 (half).
- Latency: one cycle. rsp_valid rises on the edge after fire, for loads and stores alike.
- States:
  - IDLE: no outstanding request.
    - fire -> RESP.
  - RESP: rsp_rdata formatted live from lane_rdata.
    - rsp_ready && fire -> RESP (back-to-back, one result per cycle).
    - rsp_ready && !fire -> IDLE.
    - !rsp_ready -> HOLD; formatted data is captured into the hold register at this edge, because the lane RAMs reload their address every edge.
  - HOLD: rsp_rdata comes from the hold register.
    - rsp_ready && fire -> RESP.
    - rsp_ready && !fire -> IDLE.
    - !rsp_ready -> stay in HOLD.
- Misalignment (half with off[0]=1; word with off≠0), without the feature: the low offset bits are ignored. Halves align to off[1]; words align to 0.
- Store-then-load to the same address on consecutive cycles returns the new data; the lane RAMs write first.
- Asynchronous reset mid-response drops the response. No lane write occurs after reset deassertion without a new fire.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a misaligned request is accepted but lane_we=0. The response carries rsp_err=1 and rsp_rdata=0. rsp_err is held through HOLD.
- Undefined: rsp_err is tied 0 and offsets are force-aligned as above.

Decomposition:
- Shared package dmem_pkg: size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), state enum (IDLE, RESP, HOLD), lane count constant 4.
- One sub-module, dmem_load_align: combinational extract/extend from lane_rdata, captured off, size and signed. Instantiated once, feeding both the live path and the hold capture.

Test Plan:
- Store word 0xDEADBEEF @0x010; next cycle load word @0x010 -> lane_we=4'b1111; rsp_rdata=0xDEADBEEF one cycle after the load fire.
- Store byte 0x5A @0x013 -> lane_we=4'b1000 and lane_wdata=0x5A5A5A5A. Signed byte load @0x013 after 0x80 is stored there -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half load @0x012 with memory word 0x8001_1234: signed -> 0xFFFF8001; unsigned @0x010 -> 0x00001234.
- Hold rsp_ready=0 for 3 cycles after a load of 0xCAFEF00D while req_addr changes -> rsp_rdata stays 0xCAFEF00D, req_ready=0. On rsp_ready=1, retire and accept the next request in the same cycle.
- Back-to-back loads @0x000,0x004,0x008 with rsp_ready=1 -> three responses on consecutive cycles, in order.
- With DMEM_MISALIGN_TRAP_EN: word store @0x011 -> lane_we=0, rsp_err=1, rsp_rdata=0. Without it: the same store writes @0x010 with lane_we=4'b1111. Assert rst_n=0 in RESP -> rsp_valid=0 immediately.
